// File: rtl/sa_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic-array sequencer.
// Phase lengths are functions because they depend on per-instance parameters.
package sa_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  // Never returns 0 so that a 1-wide index still gets a real bit.
  function automatic int clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int feed_len(input int n);
    return 2 * n;
  endfunction

  function automatic int drain_len(input int n, input int xlat);
    return n + xlat;
  endfunction

  function automatic int phase_cnt_w(input int n, input int xlat);
    int longest;
    longest = (feed_len(n) > drain_len(n, xlat)) ? feed_len(n) : drain_len(n, xlat);
    return clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// Control, operand-buffer and result-handshake signals of the sequencer.
// master = sequencer side, slave = host / buffer / consumer side.
interface sa_seq_ctrl_if
  import sa_seq_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16
);
  localparam int KW = clog2(N);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [KW-1:0]     rd_k;
  logic [N*DW-1:0]   a_col;
  logic [N*DW-1:0]   b_row;
  logic [KW-1:0]     res_row;
  logic              res_valid;
  logic              res_ready;

  modport master (
    input  start, a_col, b_row, res_ready,
    output busy, done, rd_en, rd_k, res_row, res_valid
  );

  modport slave (
    output start, a_col, b_row, res_ready,
    input  busy, done, rd_en, rd_k, res_row, res_valid
  );

endinterface

// File: rtl/sa_seq_ctrl_skew.sv
// Reset-to-zero register delay line; DEPTH registers between d_i and q_o.
module sa_skew_line
  import sa_seq_ctrl_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DEPTH-1:0][DW-1:0] stage_q;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= d_i;
      end
    end
  end else begin : g_chain
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[DEPTH-2:0], d_i};
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clear, skewed
// operand feed, drain, then result rows handed out over valid/ready.
module sa_seq_ctrl
  import sa_seq_ctrl_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int XLAT = 0
) (
  input  logic            clk,
  input  logic            reset,
  sa_seq_ctrl_if.master   bus,
  output logic [N*DW-1:0] west_o,
  output logic [N*DW-1:0] north_o,
  output logic            arr_clr
);

  localparam int KW        = clog2(N);
  localparam int FEED_LEN  = feed_len(N);
  localparam int DRAIN_LEN = drain_len(N, XLAT);
  localparam int CW        = phase_cnt_w(N, XLAT);

  localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN - 1);
  localparam logic [CW-1:0] K_COUNT    = CW'(N);
  localparam logic [KW-1:0] ROW_LAST   = KW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic [KW-1:0] res_row_q, res_row_d;
  logic          done_q, done_d;
  logic          feed_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      res_row_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      res_row_q <= res_row_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    res_row_d = res_row_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        t_d     = '0;
      end
      ST_FEED: begin
        if (t_q == FEED_LAST) begin
          state_d = ST_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (t_q == DRAIN_LAST) begin
          state_d   = ST_READ;
          t_d       = '0;
          res_row_d = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_READ: begin
        if (bus.res_ready) begin
          if (res_row_q == ROW_LAST) begin
            state_d   = ST_IDLE;
            res_row_d = '0;
            done_d    = 1'b1;
          end else begin
            res_row_d = res_row_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operands are only read in the first half of FEED; the second half lets
  // the longest skew line empty onto the edge.
  assign feed_en = (state_q == ST_FEED) && (t_q < K_COUNT);

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.rd_en     = feed_en;
  assign bus.rd_k      = feed_en ? t_q[KW-1:0] : '0;
  assign bus.res_row   = res_row_q;
  assign bus.res_valid = (state_q == ST_READ);
  assign arr_clr       = (state_q == ST_CLEAR);

  // Lane gi gets gi+1 registers so the wavefront enters the grid diagonally.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    assign a_in = feed_en ? bus.a_col[gi*DW +: DW] : '0;
    assign b_in = feed_en ? bus.b_row[gi*DW +: DW] : '0;

    sa_skew_line #(
      .DW    (DW),
      .DEPTH (gi + 1)
    ) u_west (
      .clk   (clk),
      .reset (reset),
      .d_i   (a_in),
      .q_o   (west_o[gi*DW +: DW])
    );

    sa_skew_line #(
      .DW    (DW),
      .DEPTH (gi + 1)
    ) u_north (
      .clk   (clk),
      .reset (reset),
      .d_i   (b_in),
      .q_o   (north_o[gi*DW +: DW])
    );
  end

endmodule
